dec_register: RTL and testbench
===============================

// Module: dec_register
// PURPOSE
//  Loadable down-counting register, the decrement-side counterpart of the incrementing PC/address register.
//  Used by the core control unit as a loop/delay counter: loaded from the datapath, decremented on command
//  or autonomously.
//  Reports zero, underflow and a one-cycle done pulse when an autonomous countdown expires.
// PARAMETERS
//  WIDTH      12  data width of dataIn/dataOut
//  RESET_VAL  0   dataOut value on reset (WIDTH bits)
//  WRAP       1   1: decrement at 0 wraps to all-ones; 0: saturates at 0
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  dataIn     in   WIDTH  load value for wrEn/startEn
//  wrEn       in   1      load dataIn, abort any countdown
//  decEn      in   1      decrement dataOut by 1 (IDLE only)
//  startEn    in   1      load dataIn and start autonomous countdown
//  dataOut    out  WIDTH  current register value
//  zero       out  1      combinational, dataOut == 0
//  underflow  out  1      registered 1-cycle pulse: decEn applied while dataOut == 0
//  busy       out  1      state == RUN
//  done       out  1      registered 1-cycle pulse: countdown reached 0
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-RUN):
//    dataOut=RESET_VAL, state=IDLE, underflow=0, done=0, busy=0.
//  - States: IDLE, RUN. Per-edge priority: wrEn > startEn > decEn/auto-decrement.
//  - wrEn: dataOut<=dataIn, state<=IDLE, done/underflow<=0. Aborting a RUN gives no done.
//  - startEn, dataIn!=0: dataOut<=dataIn, state<=RUN.
//  - startEn, dataIn==0: dataOut<=0, state stays IDLE, done<=1 at the same edge.
//  - startEn in RUN: restarts with the new dataIn; same rules apply.
//  - IDLE + decEn, dataOut!=0: dataOut<=dataOut-1.
//  - IDLE + decEn, dataOut==0:
//    - underflow<=1.
//    - dataOut<=all-ones if WRAP=1, else stays 0.
//  - RUN: dataOut<=dataOut-1 every edge; decEn is ignored.
//    - When dataOut==1: that edge sets dataOut<=0, state<=IDLE, done<=1.
//  - Countdown latency: load N (N>=1) at edge t0; done=1 and dataOut=0 are visible after edge t0+N.
//    busy is high for N cycles.
//  - done and underflow are high for exactly one cycle; both deassert on the next edge unless re-triggered.
//  - Arithmetic is modulo 2^WIDTH; no carry/borrow beyond underflow.
//  - zero follows dataOut combinationally in all states.
// TESTING
//  1. rst=1 then released, WIDTH=12 -> dataOut=0, zero=1, busy=0, done=0, underflow=0.
//  2. wrEn with dataIn=23, then decEn for 3 cycles -> dataOut 22,21,20; zero=0; underflow never set.
//  3. startEn with dataIn=5 -> busy high 5 cycles, dataOut 5,4,3,2,1,0; done=1 only in the cycle
//     dataOut first shows 0; decEn pulses during RUN have no effect.
//  4. dataOut=0 in IDLE, decEn=1:
//     - WRAP=1 -> dataOut=4095, underflow 1 cycle.
//     - WRAP=0 -> dataOut=0, underflow 1 cycle.
//  5. Simultaneous events:
//     - wrEn=1, decEn=1, dataIn=36 -> dataOut=36.
//     - wrEn at RUN count 3 -> dataOut=dataIn, busy=0, no done.
//     - startEn with dataIn=0 -> done same edge, busy stays 0.
//  6. rst asserted mid-RUN (count 7) asynchronously -> dataOut=RESET_VAL immediately, busy=0,
//     no done; 10 cycles of random wrEn/decEn/startEn/dataIn checked against a reference model.

Source files
------------

// File: rtl/dec_register.sv
// Loadable down-counting register with autonomous countdown.
// Flags zero, underflow pulse and a done pulse on countdown expiry.
module dec_register #(
  parameter int unsigned WIDTH = 12,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             wrEn,
  input  logic             decEn,
  input  logic             startEn,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] UNDER_VAL = WRAP ? '1 : '0;

  logic inZero;
  logic outZero;
  logic outOne;

  assign inZero  = (dataIn == '0);
  assign outZero = (dataOut == '0);
  assign outOne  = (dataOut == ONE);

  // Zero flag tracks the register value directly.
  assign zero = outZero;
  assign busy = (state == RUN);

  // Load/start/decrement sequencing with wrEn > startEn > decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut   <= RESET_VAL;
      state     <= IDLE;
      underflow <= 1'b0;
      done      <= 1'b0;
    end else begin
      underflow <= 1'b0;
      done      <= 1'b0;
      if (wrEn) begin
        dataOut <= dataIn;
        state   <= IDLE;
      end else if (startEn) begin
        dataOut <= dataIn;
        if (inZero) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          state <= RUN;
        end
      end else begin
        unique case (state)
          RUN: begin
            dataOut <= dataOut - ONE;
            if (outOne) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          IDLE: begin
            if (decEn) begin
              if (outZero) begin
                dataOut   <= UNDER_VAL;
                underflow <= 1'b1;
              end else begin
                dataOut <= dataOut - ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec_register.sv
// Directed bench for dec_register, wrapping and saturating variants.
// Packed vector compare: {dataOut, zero, busy, done, underflow}.
module tb_dec_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] dataIn = '0;
  logic        wrEn = 1'b0;
  logic        decEn = 1'b0;
  logic        startEn = 1'b0;

  logic [11:0] dOutW, dOutS;
  logic        zeroW, zeroS, undW, undS;
  logic        busyW, busyS, doneW, doneS;

  int nTests = 0;
  int nFail = 0;

  logic [15:0] obsW, obsS, expW, expS;

  dec_register #(.WIDTH(12), .RESET_VAL(12'd0), .WRAP(1'b1)) dutW (
    .clk(clk), .rst(rst), .dataIn(dataIn), .wrEn(wrEn),
    .decEn(decEn), .startEn(startEn), .dataOut(dOutW),
    .zero(zeroW), .underflow(undW), .busy(busyW), .done(doneW)
  );

  dec_register #(.WIDTH(12), .RESET_VAL(12'd0), .WRAP(1'b0)) dutS (
    .clk(clk), .rst(rst), .dataIn(dataIn), .wrEn(wrEn),
    .decEn(decEn), .startEn(startEn), .dataOut(dOutS),
    .zero(zeroS), .underflow(undS), .busy(busyS), .done(doneS)
  );

  always #5 clk = ~clk;

  assign obsW = {dOutW, zeroW, busyW, doneW, undW};
  assign obsS = {dOutS, zeroS, busyS, doneS, undS};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic [11:0] d,
                                     input logic b,
                                     input logic dn,
                                     input logic u);
    return {d, (d == 12'd0), b, dn, u};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    nTests++;
    if (obsW !== pk(12'd0, 0, 0, 0)) begin
      nFail++;
      $display("FAIL reset_wrap got=%h exp=%h", obsW, pk(12'd0, 0, 0, 0));
    end
    nTests++;
    if (obsS !== pk(12'd0, 0, 0, 0)) begin
      nFail++;
      $display("FAIL reset_sat got=%h exp=%h", obsS, pk(12'd0, 0, 0, 0));
    end
  endtask

  task automatic test_load_dec();
    wrEn = 1'b1;
    dataIn = 12'd23;
    tick();
    wrEn = 1'b0;
    nTests++;
    if (obsW !== pk(12'd23, 0, 0, 0)) begin
      nFail++;
      $display("FAIL load23 got=%h exp=%h", obsW, pk(12'd23, 0, 0, 0));
    end
    decEn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expW = pk(12'(23 - i), 0, 0, 0);
      nTests++;
      if (obsW !== expW) begin
        nFail++;
        $display("FAIL dec_step%0d got=%h exp=%h", i, obsW, expW);
      end
    end
    decEn = 1'b0;
  endtask

  task automatic test_countdown();
    startEn = 1'b1;
    dataIn = 12'd5;
    tick();
    startEn = 1'b0;
    nTests++;
    if (obsW !== pk(12'd5, 1, 0, 0)) begin
      nFail++;
      $display("FAIL cd_start got=%h exp=%h", obsW, pk(12'd5, 1, 0, 0));
    end
    decEn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      expW = pk(12'(5 - k), k < 5, k == 5, 0);
      nTests++;
      if (obsW !== expW) begin
        nFail++;
        $display("FAIL cd_step%0d got=%h exp=%h", k, obsW, expW);
      end
    end
    decEn = 1'b0;
    tick();
    nTests++;
    if (obsW !== pk(12'd0, 0, 0, 0)) begin
      nFail++;
      $display("FAIL cd_after got=%h exp=%h", obsW, pk(12'd0, 0, 0, 0));
    end
  endtask

  task automatic test_underflow();
    wrEn = 1'b1;
    dataIn = 12'd0;
    tick();
    wrEn = 1'b0;
    decEn = 1'b1;
    tick();
    decEn = 1'b0;
    nTests++;
    if (obsW !== pk(12'hfff, 0, 0, 1)) begin
      nFail++;
      $display("FAIL uf_wrap got=%h exp=%h", obsW, pk(12'hfff, 0, 0, 1));
    end
    nTests++;
    if (obsS !== pk(12'd0, 0, 0, 1)) begin
      nFail++;
      $display("FAIL uf_sat got=%h exp=%h", obsS, pk(12'd0, 0, 0, 1));
    end
    tick();
    nTests++;
    if (obsW !== pk(12'hfff, 0, 0, 0)) begin
      nFail++;
      $display("FAIL uf_wrap_clr got=%h exp=%h", obsW, pk(12'hfff, 0, 0, 0));
    end
    nTests++;
    if (obsS !== pk(12'd0, 0, 0, 0)) begin
      nFail++;
      $display("FAIL uf_sat_clr got=%h exp=%h", obsS, pk(12'd0, 0, 0, 0));
    end
  endtask

  task automatic test_simultaneous();
    wrEn = 1'b1;
    decEn = 1'b1;
    dataIn = 12'd36;
    tick();
    wrEn = 1'b0;
    decEn = 1'b0;
    nTests++;
    if (obsW !== pk(12'd36, 0, 0, 0)) begin
      nFail++;
      $display("FAIL wr_dec got=%h exp=%h", obsW, pk(12'd36, 0, 0, 0));
    end
    startEn = 1'b1;
    dataIn = 12'd10;
    tick();
    startEn = 1'b0;
    repeat (7) tick();
    nTests++;
    if (obsW !== pk(12'd3, 1, 0, 0)) begin
      nFail++;
      $display("FAIL run_at3 got=%h exp=%h", obsW, pk(12'd3, 1, 0, 0));
    end
    wrEn = 1'b1;
    dataIn = 12'd99;
    tick();
    wrEn = 1'b0;
    nTests++;
    if (obsW !== pk(12'd99, 0, 0, 0)) begin
      nFail++;
      $display("FAIL abort got=%h exp=%h", obsW, pk(12'd99, 0, 0, 0));
    end
    tick();
    nTests++;
    if (obsW !== pk(12'd99, 0, 0, 0)) begin
      nFail++;
      $display("FAIL abort_hold got=%h exp=%h", obsW, pk(12'd99, 0, 0, 0));
    end
    startEn = 1'b1;
    dataIn = 12'd0;
    tick();
    startEn = 1'b0;
    nTests++;
    if (obsW !== pk(12'd0, 0, 1, 0)) begin
      nFail++;
      $display("FAIL start0 got=%h exp=%h", obsW, pk(12'd0, 0, 1, 0));
    end
    tick();
    nTests++;
    if (obsW !== pk(12'd0, 0, 0, 0)) begin
      nFail++;
      $display("FAIL start0_clr got=%h exp=%h", obsW, pk(12'd0, 0, 0, 0));
    end
  endtask

  task automatic test_async_random();
    logic [11:0] md [2];
    logic        mr [2];
    logic        mdn [2];
    logic        mu [2];
    startEn = 1'b1;
    dataIn = 12'd12;
    tick();
    startEn = 1'b0;
    repeat (5) tick();
    nTests++;
    if (obsW !== pk(12'd7, 1, 0, 0)) begin
      nFail++;
      $display("FAIL run_at7 got=%h exp=%h", obsW, pk(12'd7, 1, 0, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    nTests++;
    if (obsW !== pk(12'd0, 0, 0, 0)) begin
      nFail++;
      $display("FAIL async_rst got=%h exp=%h", obsW, pk(12'd0, 0, 0, 0));
    end
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      md[w] = '0;
      mr[w] = 1'b0;
      mdn[w] = 1'b0;
      mu[w] = 1'b0;
    end
    for (int c = 0; c < 10; c++) begin
      wrEn = ($urandom_range(0, 5) == 0);
      startEn = ($urandom_range(0, 3) == 0);
      decEn = $urandom_range(0, 1) == 1;
      dataIn = 12'($urandom_range(0, 4));
      for (int w = 0; w < 2; w++) begin
        mdn[w] = 1'b0;
        mu[w] = 1'b0;
        if (wrEn) begin
          md[w] = dataIn;
          mr[w] = 1'b0;
        end else if (startEn) begin
          md[w] = dataIn;
          mr[w] = (dataIn != 0);
          mdn[w] = (dataIn == 0);
        end else if (mr[w]) begin
          md[w] = md[w] - 12'd1;
          if (md[w] == 0) begin
            mr[w] = 1'b0;
            mdn[w] = 1'b1;
          end
        end else if (decEn) begin
          if (md[w] == 0) begin
            mu[w] = 1'b1;
            md[w] = (w == 1) ? 12'hfff : 12'd0;
          end else begin
            md[w] = md[w] - 12'd1;
          end
        end
      end
      tick();
      expW = pk(md[1], mr[1], mdn[1], mu[1]);
      expS = pk(md[0], mr[0], mdn[0], mu[0]);
      nTests++;
      if (obsW !== expW) begin
        nFail++;
        $display("FAIL rand_wrap%0d got=%h exp=%h", c, obsW, expW);
      end
      nTests++;
      if (obsS !== expS) begin
        nFail++;
        $display("FAIL rand_sat%0d got=%h exp=%h", c, obsS, expS);
      end
    end
    wrEn = 1'b0;
    startEn = 1'b0;
    decEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_dec();
    test_countdown();
    test_underflow();
    test_simultaneous();
    test_async_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
